// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer.
//   - state_e        : FSM state encoding (IDLE, ISSUE, CAPTURE, DONE)
//   - FLAG_*         : bit positions inside the 5-bit flag vector
//                      {lcarry, acarry, zero, sign, overflow}
//   - OP_*_DEF       : default ALU operation codes
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int FLAG_W        = 5;
  localparam int FLAG_LCARRY   = 4;
  localparam int FLAG_ACARRY   = 3;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_SIGN     = 1;
  localparam int FLAG_OVERFLOW = 0;

  localparam logic [3:0] OP_ADD_DEF = 4'h0;
  localparam logic [3:0] OP_ADC_DEF = 4'h1;
  localparam logic [3:0] OP_SUB_DEF = 4'h2;
  localparam logic [3:0] OP_SBB_DEF = 4'h3;

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the sequencer and the external word-wide ALU.
//   master (sequencer): drives alu_lhs, alu_rhs, alu_op, alu_assert;
//                       receives alu_bus, alu_bus_en_n, alu_flags.
//   slave  (ALU)      : the reverse directions.
// alu_bus_en_n is active-low: the ALU pulls it low in the cycle its result
// on alu_bus (and alu_flags) is valid.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] alu_lhs;
  logic [WIDTH-1:0] alu_rhs;
  logic [3:0]       alu_op;
  logic             alu_assert;
  logic [WIDTH-1:0] alu_bus;
  logic             alu_bus_en_n;
  logic [4:0]       alu_flags;

  modport master (
    output alu_lhs, alu_rhs, alu_op, alu_assert,
    input  alu_bus, alu_bus_en_n, alu_flags
  );

  modport slave (
    input  alu_lhs, alu_rhs, alu_op, alu_assert,
    output alu_bus, alu_bus_en_n, alu_flags
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences a WIDTH*WORDS add/subtract through an external
// WIDTH-bit ALU, least significant word first, chaining the carry through
// the ALU's ADC/SBB operations.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request pulse, taken only while ready=1
//   sub              : 0 = A+B, 1 = A-B (sampled with start)
//   a_in, b_in       : WIDTH*WORDS operands (sampled with start)
//   ready            : high in IDLE and DONE
//   done             : one-cycle pulse, result/flags valid
//   result           : full-width result, held until the next accepted start
//   flags_out        : {lcarry, acarry, zero, sign, overflow} of the full result
//   alu (master)     : per-word operands/opcode/request out, bus/flags in
//
// Build option
//   ALU_SEQ_FLAGS_EN : when defined, flags_out carries the accumulated flags;
//                      otherwise flags_out is tied to zero and no flag
//                      storage exists.
//
// Timing without bus waits: the start-accept edge is edge 1 and done is
// high after edge 2*WORDS+1 (ISSUE/CAPTURE per word).
module alu_seq #(
  parameter int         WIDTH  = 8,
  parameter int         WORDS  = 2,
  parameter logic [3:0] OP_ADD = alu_seq_pkg::OP_ADD_DEF,
  parameter logic [3:0] OP_ADC = alu_seq_pkg::OP_ADC_DEF,
  parameter logic [3:0] OP_SUB = alu_seq_pkg::OP_SUB_DEF,
  parameter logic [3:0] OP_SBB = alu_seq_pkg::OP_SBB_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WIDTH*WORDS-1:0]   a_in,
  input  logic [WIDTH*WORDS-1:0]   b_in,
  output logic                     ready,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   result,
  output logic [4:0]               flags_out,
  alu_seq_if.master                alu
);
  import alu_seq_pkg::*;

  localparam int TOT_W = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  function automatic logic [WIDTH-1:0] word_of(input logic [TOT_W-1:0] v,
                                               input logic [IDX_W-1:0] i);
    return v[int'(i)*WIDTH +: WIDTH];
  endfunction

  // First word starts a fresh add/subtract; later words chain the carry.
  function automatic logic [3:0] op_for(input logic is_sub, input logic first);
    if (first) return is_sub ? OP_SUB : OP_ADD;
    else       return is_sub ? OP_SBB : OP_ADC;
  endfunction

  state_e           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [TOT_W-1:0] result_q, result_d;
  logic [TOT_W-1:0] a_q,      a_d;
  logic [TOT_W-1:0] b_q,      b_d;
  logic             sub_q,    sub_d;
  logic             done_q,   done_d;
  logic             assert_q, assert_d;
  logic [WIDTH-1:0] lhs_q,    lhs_d;
  logic [WIDTH-1:0] rhs_q,    rhs_d;
  logic [3:0]       op_q,     op_d;

  logic             accept;
  logic             bus_cap;
  logic             last_word;
  logic [IDX_W-1:0] idx_nxt;

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = ready && start;
  assign bus_cap   = (state_q == ST_CAPTURE) && !alu.alu_bus_en_n;
  assign last_word = (idx_q == LAST_IDX);
  assign idx_nxt   = idx_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    op_d     = op_q;
    assert_d = assert_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          // Outputs are registered, so word 0 is presented as ISSUE begins.
          a_d      = a_in;
          b_d      = b_in;
          sub_d    = sub;
          idx_d    = '0;
          result_d = '0;
          lhs_d    = word_of(a_in, '0);
          rhs_d    = word_of(b_in, '0);
          op_d     = op_for(sub, 1'b1);
          assert_d = 1'b1;
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // No timeout: a stalled ALU holds the sequencer here indefinitely.
        if (bus_cap) begin
          result_d[int'(idx_q)*WIDTH +: WIDTH] = alu.alu_bus;
          if (last_word) begin
            lhs_d    = '0;
            rhs_d    = '0;
            op_d     = '0;
            assert_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            idx_d   = idx_nxt;
            lhs_d   = word_of(a_q, idx_nxt);
            rhs_d   = word_of(b_q, idx_nxt);
            op_d    = op_for(sub_q, 1'b0);
            state_d = ST_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      op_q     <= '0;
      assert_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      op_q     <= op_d;
      assert_q <= assert_d;
      done_q   <= done_d;
    end
  end

  // Latched operands are only read after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              zacc_q,  zacc_d;

  // zero must hold across every word; the other flags describe the top word.
  always_comb begin
    flags_d = flags_q;
    zacc_d  = zacc_q;
    if (accept) begin
      flags_d = '0;
      zacc_d  = 1'b1;
    end else if (bus_cap) begin
      zacc_d = zacc_q & alu.alu_flags[FLAG_ZERO];
      if (last_word) begin
        flags_d            = alu.alu_flags;
        flags_d[FLAG_ZERO] = zacc_q & alu.alu_flags[FLAG_ZERO];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      zacc_q  <= 1'b1;
    end else begin
      flags_q <= flags_d;
      zacc_q  <= zacc_d;
    end
  end

  assign flags_out = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^alu.alu_flags;
  assign flags_out    = 5'b0;
`endif

  assign done           = done_q;
  assign result         = result_q;
  assign alu.alu_lhs    = lhs_q;
  assign alu.alu_rhs    = rhs_q;
  assign alu.alu_op     = op_q;
  assign alu.alu_assert = assert_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, ALU word width in bits.
REQ-002 Parameter WORDS, default 2, number of ALU words per operand (range 1..8).
REQ-003 Parameters OP_ADD/OP_ADC/OP_SUB/OP_SBB, defaults 4'h0/4'h1/4'h2/4'h3, ALU operation codes driven for first/subsequent words.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request pulse; sampled only when ready=1.
REQ-008 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-009 a_in, b_in  input  WIDTH*WORDS  operands; sampled with start.
REQ-010 ready  output  1  high when a new start will be accepted.
REQ-011 done  output  1  one-cycle pulse, result/flags valid.
REQ-012 result  output  WIDTH*WORDS  multi-word result, held until next accepted start.
REQ-013 flags_out  output  5  {lcarry, acarry, zero, sign, overflow} for full-width result.
REQ-014 alu_lhs, alu_rhs  output  WIDTH  current word operands to ALU.
REQ-015 alu_op  output  4  current ALU operation code.
REQ-016 alu_assert  output  1  active-high request for ALU to drive bus.
REQ-017 alu_bus  input  WIDTH  ALU result bus.
REQ-018 alu_bus_en_n  input  1  ALU bus enable, active-low; capture qualified on it.
REQ-019 alu_flags  input  5  ALU flag vector, same bit order as flags_out.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE; word index counter 0..WORDS-1, LSW first.
REQ-021 IDLE or DONE with start=1 SHALL latch operands/sub, clear index and result, go to ISSUE; ready=1 only in IDLE and DONE.
REQ-022 ISSUE SHALL drive word[index] of A and B, alu_op = (index==0 ? OP_ADD/OP_SUB : OP_ADC/OP_SBB) per sub, alu_assert=1, and go to CAPTURE.
REQ-023 CAPTURE SHALL hold alu_lhs/alu_rhs/alu_op/alu_assert unchanged from ISSUE.
REQ-024 CAPTURE with alu_bus_en_n=0 SHALL write alu_bus into result word[index]; with alu_bus_en_n=1 SHALL stay in CAPTURE (wait, no timeout).
REQ-025 After capture: index<WORDS-1 -> increment, ISSUE; index==WORDS-1 -> DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE unless start=1.
REQ-027 Latency with no waits SHALL be 2*WORDS+1 cycles from start-accept edge to done=1 (5 for WORDS=2).
REQ-028 start while ready=0 SHALL be ignored with no state change.
REQ-029 alu_assert SHALL be 0 in IDLE and DONE; alu_lhs/alu_rhs/alu_op SHALL be 0 there.
REQ-030 zero flag SHALL be AND of per-word ALU zero flags; acarry, sign, overflow, lcarry SHALL be from the last word's capture.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, index=0, result=0, flags_out=0, done=0, alu_assert=0, alu_lhs/alu_rhs/alu_op=0, ready=1, including mid-operation; no done for the aborted request.

Configuration
REQ-032 Macro ALU_SEQ_FLAGS_EN defined: flags_out per REQ-030; undefined: flags_out tied to 5'b0 and no flag storage.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, flag bit-index constants, default op codes.
REQ-034 Single module; no sub-module; ALU is external and instantiated alongside at the next level.

Verification (WIDTH=8, WORDS=2, real alu attached)
REQ-035 A=0x12FF, B=0x0001, sub=0 -> result 0x1300, acarry=0, zero=0, done 5 cycles after start.
REQ-036 A=0xFFFF, B=0x0001, sub=0 -> result 0x0000, acarry=1, zero=1.
REQ-037 A=0x7FFF, B=0x0001, sub=0 -> result 0x8000, sign=1, overflow=1.
REQ-038 A=0x1000, B=0x0001, sub=1 -> result 0x0FFF, zero=0.
REQ-039 start pulsed during CAPTURE of word 0 -> ignored, original result delivered; rst_n=0 in ISSUE of word 1 -> IDLE, no done, outputs 0.
REQ-040 alu_bus_en_n held high 3 cycles in CAPTURE -> done delayed exactly 3 cycles, result unchanged.
